// File: rtl/axis_pkt_sum_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_pkt_sum_pkg                                                         |
// | Shared constants, FSM state type and record-width helper.                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package axis_pkt_sum_pkg;

  localparam int ERR_STABLE = 0;
  localparam int ERR_ROUTE  = 1;
  localparam int ERR_STRB   = 2;
  localparam int ERR_SAT    = 3;
  localparam int ERR_W      = 4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

  typedef enum logic [0:0] {
    IDLE   = ST_IDLE,
    IN_PKT = ST_IN_PKT
  } pkt_state_e;

  function automatic int rec_width(input int beat_w, input int byte_w, input int tid_w,
                                   input int tdest_w, input int ts_w);
    return beat_w + byte_w + tid_w + tdest_w + ERR_W + ts_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_pkt_sum_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_pkt_sum_fifo                                                        |
// | 2-entry valid/ready FIFO; flags a push that finds no room.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module axis_pkt_sum_fifo
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push_valid,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_push_drop,
  output logic             o_pop_valid,
  output logic [WIDTH-1:0] o_pop_data,
  input  logic             i_pop_ready
);

  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             w_pop;
  logic             w_push;

  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  always_comb begin
    w_pop       = i_pop_ready && (cnt_q != 2'd0);
    w_push      = i_push_valid && ((cnt_q != 2'd2) || w_pop);
    o_push_drop = i_push_valid && !w_push;
    cnt_d       = cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    case ({w_push, w_pop})
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = i_push_data;
        end else begin
          head_d = tail_q;
          tail_d = i_push_data;
        end
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = i_push_data;
        end else begin
          tail_d = i_push_data;
        end
        cnt_d = cnt_q + 2'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign o_pop_valid = (cnt_q != 2'd0);
  assign o_pop_data  = head_q;

endmodule
`default_nettype wire

// File: rtl/axis_pkt_summarizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_pkt_summarizer                                                      |
// | Passive AXI-Stream tap emitting one summary record per packet.           |
// | Optional: AXIS_PKT_SUM_TIMESTAMP_EN adds SUM_TS (first-beat cycle).      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module axis_pkt_summarizer
  import axis_pkt_sum_pkg::*;
#(
  parameter int TDATA_WIDTH    = 32,
  parameter int TID_WIDTH      = 4,
  parameter int TDEST_WIDTH    = 4,
  parameter int TUSER_WIDTH    = 1,
  parameter int BEAT_CNT_WIDTH = 16
) (
  input  logic                                              ACLK,
  input  logic                                              ARESETn,
  input  logic                                              TVALID,
  input  logic                                              TREADY,
  input  logic                                              TLAST,
  input  logic [TDATA_WIDTH-1:0]                            TDATA,
  input  logic [TDATA_WIDTH/8-1:0]                          TSTRB,
  input  logic [TDATA_WIDTH/8-1:0]                          TKEEP,
  input  logic [TID_WIDTH-1:0]                              TID,
  input  logic [TDEST_WIDTH-1:0]                            TDEST,
  input  logic [TUSER_WIDTH-1:0]                            TUSER,
  input  logic                                              TREADY_EN,
  output logic                                              SUM_VALID,
  input  logic                                              SUM_READY,
  output logic [BEAT_CNT_WIDTH-1:0]                         SUM_BEATS,
  output logic [BEAT_CNT_WIDTH+$clog2(TDATA_WIDTH/8+1)-1:0] SUM_BYTES,
  output logic [TID_WIDTH-1:0]                              SUM_TID,
  output logic [TDEST_WIDTH-1:0]                            SUM_TDEST,
  output logic [3:0]                                        SUM_ERR,
`ifdef AXIS_PKT_SUM_TIMESTAMP_EN
  output logic [31:0]                                       SUM_TS,
`endif
  output logic [15:0]                                       DROP_CNT
);

  localparam int NB     = TDATA_WIDTH / 8;
  localparam int PC_W   = $clog2(NB + 1);
  localparam int BYTE_W = BEAT_CNT_WIDTH + PC_W;
`ifdef AXIS_PKT_SUM_TIMESTAMP_EN
  localparam int TS_W   = 32;
`else
  localparam int TS_W   = 0;
`endif
  localparam int REC_W  = rec_width(BEAT_CNT_WIDTH, BYTE_W, TID_WIDTH, TDEST_WIDTH, TS_W);
  localparam int PL_W   = TDATA_WIDTH + 2 * NB + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

  pkt_state_e                state_q, state_d;
  logic [BEAT_CNT_WIDTH-1:0] beats_q, beats_d;
  logic [BYTE_W-1:0]         bytes_q, bytes_d;
  logic [TID_WIDTH-1:0]      tid_q, tid_d;
  logic [TDEST_WIDTH-1:0]    tdest_q, tdest_d;
  logic [ERR_W-1:0]          err_q, err_d;
  logic                      stall_q, stall_d;
  logic [PL_W-1:0]           pl_q, pl_d;
  logic [15:0]               drop_cnt_q, drop_cnt_d;

  logic                      w_acc;
  logic                      w_first;
  logic                      w_complete;
  logic [PC_W-1:0]           w_keep_cnt;
  logic [PL_W-1:0]           w_pl;
  logic [BEAT_CNT_WIDTH:0]   w_beats_ext;
  logic [BYTE_W:0]           w_bytes_ext;
  logic [BEAT_CNT_WIDTH-1:0] w_beats_new;
  logic [BYTE_W-1:0]         w_bytes_new;
  logic [TID_WIDTH-1:0]      w_rec_tid;
  logic [TDEST_WIDTH-1:0]    w_rec_tdest;
  logic [ERR_W-1:0]          w_err_now;
  logic [REC_W-1:0]          w_rec;
  logic [REC_W-1:0]          w_sum_rec;
  logic                      w_drop;

`ifdef AXIS_PKT_SUM_TIMESTAMP_EN
  logic [31:0]               ts_cnt_q, ts_cnt_d;
  logic [31:0]               ts_q, ts_d;
  logic [31:0]               w_rec_ts;
`endif

  always_comb begin
    w_keep_cnt = '0;
    for (int i = 0; i < NB; i++) begin
      w_keep_cnt = w_keep_cnt + PC_W'(TKEEP[i]);
    end
  end

  always_comb begin
    w_acc       = TVALID && (TREADY || !TREADY_EN);
    w_first     = (state_q == IDLE);
    w_complete  = w_acc && TLAST;
    w_pl        = {TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER};

    w_beats_ext = w_first ? (BEAT_CNT_WIDTH + 1)'(1)
                          : {1'b0, beats_q} + (BEAT_CNT_WIDTH + 1)'(1);
    w_bytes_ext = w_first ? (BYTE_W + 1)'(w_keep_cnt)
                          : {1'b0, bytes_q} + (BYTE_W + 1)'(w_keep_cnt);
    w_beats_new = w_beats_ext[BEAT_CNT_WIDTH] ? '1 : w_beats_ext[BEAT_CNT_WIDTH-1:0];
    w_bytes_new = w_bytes_ext[BYTE_W] ? '1 : w_bytes_ext[BYTE_W-1:0];

    w_rec_tid   = w_first ? TID : tid_q;
    w_rec_tdest = w_first ? TDEST : tdest_q;

    // A stall-time violation seen while idle lands in err_q and rides along with the next packet.
    w_err_now             = err_q;
    w_err_now[ERR_STABLE] = err_q[ERR_STABLE] || (stall_q && (!TVALID || (w_pl != pl_q)));
    w_err_now[ERR_ROUTE]  = err_q[ERR_ROUTE] ||
                            (w_acc && !w_first && ((TID != tid_q) || (TDEST != tdest_q)));
    w_err_now[ERR_STRB]   = err_q[ERR_STRB] || (w_acc && ((TSTRB & ~TKEEP) != '0));
    w_err_now[ERR_SAT]    = err_q[ERR_SAT] ||
                            (w_acc && (w_beats_ext[BEAT_CNT_WIDTH] || w_bytes_ext[BYTE_W]));
  end

  always_comb begin
    state_d    = state_q;
    beats_d    = beats_q;
    bytes_d    = bytes_q;
    tid_d      = tid_q;
    tdest_d    = tdest_q;
    err_d      = w_err_now;
    stall_d    = TVALID && !w_acc;
    pl_d       = w_pl;
    drop_cnt_d = drop_cnt_q;

    if (w_acc) begin
      beats_d = w_beats_new;
      bytes_d = w_bytes_new;
      tid_d   = w_rec_tid;
      tdest_d = w_rec_tdest;
      if (w_complete) begin
        state_d = IDLE;
        err_d   = '0;
      end else begin
        state_d = IN_PKT;
      end
    end

    if (w_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

`ifdef AXIS_PKT_SUM_TIMESTAMP_EN
  always_comb begin
    ts_cnt_d = ts_cnt_q + 32'd1;
    w_rec_ts = w_first ? ts_cnt_q : ts_q;
    ts_d     = (w_acc && w_first) ? ts_cnt_q : ts_q;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ts_cnt_q <= 32'd0;
      ts_q     <= 32'd0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      ts_q     <= ts_d;
    end
  end

  assign w_rec = {w_beats_new, w_bytes_new, w_rec_tid, w_rec_tdest, w_err_now, w_rec_ts};
  assign {SUM_BEATS, SUM_BYTES, SUM_TID, SUM_TDEST, SUM_ERR, SUM_TS} = w_sum_rec;
`else
  assign w_rec = {w_beats_new, w_bytes_new, w_rec_tid, w_rec_tdest, w_err_now};
  assign {SUM_BEATS, SUM_BYTES, SUM_TID, SUM_TDEST, SUM_ERR} = w_sum_rec;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      beats_q    <= '0;
      bytes_q    <= '0;
      tid_q      <= '0;
      tdest_q    <= '0;
      err_q      <= '0;
      stall_q    <= 1'b0;
      pl_q       <= '0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      beats_q    <= beats_d;
      bytes_q    <= bytes_d;
      tid_q      <= tid_d;
      tdest_q    <= tdest_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
      pl_q       <= pl_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  axis_pkt_sum_fifo #(
    .WIDTH (REC_W)
  ) u_fifo (
    .clk          (ACLK),
    .rst_n        (ARESETn),
    .i_push_valid (w_complete),
    .i_push_data  (w_rec),
    .o_push_drop  (w_drop),
    .o_pop_valid  (SUM_VALID),
    .o_pop_data   (w_sum_rec),
    .i_pop_ready  (SUM_READY)
  );

  assign DROP_CNT = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_summarizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axis_pkt_summarizer                                                   |
// | Directed self-checking bench for axis_pkt_summarizer.                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_axis_pkt_summarizer;

  logic        ACLK      = 1'b0;
  logic        ARESETn   = 1'b0;
  logic        TVALID    = 1'b0;
  logic        TREADY    = 1'b1;
  logic        TLAST     = 1'b0;
  logic [31:0] TDATA     = 32'd0;
  logic [3:0]  TSTRB     = 4'd0;
  logic [3:0]  TKEEP     = 4'd0;
  logic [3:0]  TID       = 4'd0;
  logic [3:0]  TDEST     = 4'd0;
  logic [0:0]  TUSER     = 1'b0;
  logic        TREADY_EN = 1'b1;
  logic        SUM_READY = 1'b0;
  logic        SUM_VALID;
  logic [15:0] SUM_BEATS;
  logic [18:0] SUM_BYTES;
  logic [3:0]  SUM_TID;
  logic [3:0]  SUM_TDEST;
  logic [3:0]  SUM_ERR;
  logic [15:0] DROP_CNT;
`ifdef AXIS_PKT_SUM_TIMESTAMP_EN
  logic [31:0] SUM_TS;
`endif

  logic [31:0] tb_cyc;
  logic [31:0] ts_exp;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) tb_cyc <= 32'd0;
    else          tb_cyc <= tb_cyc + 32'd1;
  end

  axis_pkt_summarizer dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .TVALID    (TVALID),
    .TREADY    (TREADY),
    .TLAST     (TLAST),
    .TDATA     (TDATA),
    .TSTRB     (TSTRB),
    .TKEEP     (TKEEP),
    .TID       (TID),
    .TDEST     (TDEST),
    .TUSER     (TUSER),
    .TREADY_EN (TREADY_EN),
    .SUM_VALID (SUM_VALID),
    .SUM_READY (SUM_READY),
    .SUM_BEATS (SUM_BEATS),
    .SUM_BYTES (SUM_BYTES),
    .SUM_TID   (SUM_TID),
    .SUM_TDEST (SUM_TDEST),
    .SUM_ERR   (SUM_ERR),
`ifdef AXIS_PKT_SUM_TIMESTAMP_EN
    .SUM_TS    (SUM_TS),
`endif
    .DROP_CNT  (DROP_CNT)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drives one beat at a falling edge and advances to the next falling edge.
  task automatic send_beat(input logic [31:0] data, input logic [3:0] keep, input logic [3:0] strb,
                           input logic [3:0] tid, input logic [3:0] tdest, input logic last);
    TVALID = 1'b1;
    TDATA  = data;
    TKEEP  = keep;
    TSTRB  = strb;
    TID    = tid;
    TDEST  = tdest;
    TLAST  = last;
    @(negedge ACLK);
  endtask

  task automatic bus_idle();
    TVALID = 1'b0;
    TLAST  = 1'b0;
  endtask

  task automatic rec_check(input string tag, input int beats, input int bytes, input int tid,
                           input int tdest, input int err);
    int w = 0;
    while (!SUM_VALID && w < 10) begin
      @(negedge ACLK);
      w++;
    end
    check({tag, ".valid"}, 64'(SUM_VALID), 64'(1));
    check({tag, ".beats"}, 64'(SUM_BEATS), 64'(beats));
    check({tag, ".bytes"}, 64'(SUM_BYTES), 64'(bytes));
    check({tag, ".tid"},   64'(SUM_TID),   64'(tid));
    check({tag, ".tdest"}, 64'(SUM_TDEST), 64'(tdest));
    check({tag, ".err"},   64'(SUM_ERR),   64'(err));
    SUM_READY = 1'b1;
    @(negedge ACLK);
    SUM_READY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge ACLK);
    check("rst.valid", 64'(SUM_VALID), 64'(0));
    check("rst.beats", 64'(SUM_BEATS), 64'(0));
    check("rst.bytes", 64'(SUM_BYTES), 64'(0));
    check("rst.err",   64'(SUM_ERR),   64'(0));
    check("rst.drop",  64'(DROP_CNT),  64'(0));
    ARESETn = 1'b1;
    @(negedge ACLK);

    // 4-beat packet, full keep
    send_beat(32'hA0, 4'hF, 4'hF, 4'd2, 4'd5, 1'b0);
    send_beat(32'hA1, 4'hF, 4'hF, 4'd2, 4'd5, 1'b0);
    send_beat(32'hA2, 4'hF, 4'hF, 4'd2, 4'd5, 1'b0);
    check("t1.nolat", 64'(SUM_VALID), 64'(0));
    send_beat(32'hA3, 4'hF, 4'hF, 4'd2, 4'd5, 1'b1);
    bus_idle();
    check("t1.lat", 64'(SUM_VALID), 64'(1));
    rec_check("t1", 4, 16, 2, 5, 0);

    // stalled beat whose data changes mid-stall
    TREADY = 1'b0;
    TVALID = 1'b1; TLAST = 1'b1; TDATA = 32'h1111; TKEEP = 4'hF; TSTRB = 4'hF;
    TID = 4'd1; TDEST = 4'd1;
    @(negedge ACLK);
    TDATA = 32'h2222;
    @(negedge ACLK);
    @(negedge ACLK);
    TREADY = 1'b1;
    @(negedge ACLK);
    bus_idle();
    rec_check("t2", 1, 4, 1, 1, 1);
    send_beat(32'h3333, 4'hF, 4'hF, 4'd1, 4'd1, 1'b1);
    bus_idle();
    rec_check("t2b", 1, 4, 1, 1, 0);

    // TDEST changes inside packet
    send_beat(32'h10, 4'hF, 4'hF, 4'd2, 4'd5, 1'b0);
    send_beat(32'h11, 4'hF, 4'hF, 4'd2, 4'd6, 1'b0);
    send_beat(32'h12, 4'hF, 4'hF, 4'd2, 4'd6, 1'b1);
    bus_idle();
    rec_check("t3", 3, 12, 2, 5, 2);

    // strobe outside keep
    send_beat(32'h20, 4'h3, 4'h7, 4'd3, 4'd3, 1'b1);
    bus_idle();
    rec_check("t3s", 1, 2, 3, 3, 4);

    // buffer full: third record dropped
    send_beat(32'h30, 4'hF, 4'hF, 4'd1, 4'd0, 1'b1);
    send_beat(32'h31, 4'hF, 4'hF, 4'd2, 4'd0, 1'b1);
    send_beat(32'h32, 4'hF, 4'hF, 4'd3, 4'd0, 1'b1);
    bus_idle();
    check("t4.drop", 64'(DROP_CNT), 64'(1));
    check("t4.head", 64'(SUM_TID),  64'(1));
    @(negedge ACLK);
    check("t4.hold", 64'(SUM_TID),  64'(1));
    rec_check("t4a", 1, 4, 1, 0, 0);
    rec_check("t4b", 1, 4, 2, 0, 0);
    check("t4.empty", 64'(SUM_VALID), 64'(0));

    // back-to-back 1-beat packets at full rate
    SUM_READY = 1'b1;
    send_beat(32'h40, 4'hF, 4'hF, 4'd4, 4'd0, 1'b1);
    check("t5.v0",  64'(SUM_VALID), 64'(1));
    check("t5.id0", 64'(SUM_TID),   64'(4));
    send_beat(32'h41, 4'hF, 4'hF, 4'd5, 4'd0, 1'b1);
    check("t5.v1",  64'(SUM_VALID), 64'(1));
    check("t5.id1", 64'(SUM_TID),   64'(5));
    send_beat(32'h42, 4'hF, 4'hF, 4'd6, 4'd0, 1'b1);
    bus_idle();
    check("t5.v2",  64'(SUM_VALID), 64'(1));
    check("t5.id2", 64'(SUM_TID),   64'(6));
    @(negedge ACLK);
    check("t5.drain", 64'(SUM_VALID), 64'(0));
    check("t5.drop",  64'(DROP_CNT),  64'(1));
    SUM_READY = 1'b0;

    // reset mid-packet with a record buffered
    send_beat(32'h50, 4'hF, 4'hF, 4'd7, 4'd0, 1'b1);
    send_beat(32'h51, 4'hF, 4'hF, 4'd8, 4'd0, 1'b0);
    send_beat(32'h52, 4'hF, 4'hF, 4'd8, 4'd0, 1'b0);
    bus_idle();
    check("t6.pre", 64'(SUM_VALID), 64'(1));
    ARESETn = 1'b0;
    #1;
    check("t6.rvalid", 64'(SUM_VALID), 64'(0));
    check("t6.rdrop",  64'(DROP_CNT),  64'(0));
    check("t6.rbeats", 64'(SUM_BEATS), 64'(0));
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    send_beat(32'h60, 4'h3, 4'h3, 4'd9, 4'd0, 1'b1);
    bus_idle();
    rec_check("t6", 1, 2, 9, 0, 0);
    check("t6.only", 64'(SUM_VALID), 64'(0));

    // no TREADY on the bus
    TREADY_EN = 1'b0;
    TREADY    = 1'b0;
    ts_exp    = tb_cyc;
    send_beat(32'h70, 4'hF, 4'hF, 4'd1, 4'd2, 1'b0);
    send_beat(32'h71, 4'hF, 4'hF, 4'd1, 4'd2, 1'b1);
    bus_idle();
`ifdef AXIS_PKT_SUM_TIMESTAMP_EN
    check("t7.ts", 64'(SUM_TS), 64'(ts_exp));
`endif
    rec_check("t7", 2, 8, 1, 2, 0);
    TREADY_EN = 1'b1;
    TREADY    = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
